// File: rtl/alu_pkg.sv
// ==== alu_pkg : shared ALU constants, divider FSM state encoding ====
// ==== Rev 1.0                                                     ====
`default_nettype none

package alu_pkg;

  localparam int WIDTH = 8;
  localparam logic [7:0] DIV_ZERO_Q = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/seq_divider8_if.sv
// ==== seq_divider8_if : start/busy/done handshake and operand/result bus ====
// ==== Rev 1.0                                                            ====
`default_nettype none

interface seq_divider8_if #(
  parameter int WIDTH = alu_pkg::WIDTH
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

`default_nettype wire

// File: rtl/sub9_borrow.sv
// ==== sub9_borrow : ripple subtractor a - b as a + ~b + 1, with borrow-out ====
// ==== Rev 1.0                                                              ====
`default_nettype none

module sub9_borrow #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  logic [N:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_fa
    logic nb;
    assign nb         = ~b[i];
    assign diff[i]    = a[i] ^ nb ^ carry[i];
    assign carry[i+1] = (a[i] & nb) | (carry[i] & (a[i] ^ nb));
  end

  // A missing final carry means a < b.
  assign borrow = ~carry[N];

endmodule

`default_nettype wire

// File: rtl/seq_divider8.sv
// ==== seq_divider8 : restoring unsigned divider, one quotient bit per cycle ====
// ==== Rev 1.0                                                               ====
`default_nettype none

module seq_divider8
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH,
  parameter int CNT_W = 3
) (
  input  logic          clk,
  input  logic          rst,
  seq_divider8_if.slave bus
);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic             take;
  logic             accept;
  logic [WIDTH-1:0] quo_reg;
  logic [WIDTH-1:0] rem_reg;
  logic             dbz_reg;

  assign shifted = {r, dvd_reg[cnt]};

  sub9_borrow #(
    .N (WIDTH + 1)
  ) u_sub (
    .a      (shifted),
    .b      ({1'b0, dvs_reg}),
    .diff   (trial),
    .borrow (borrow)
  );

  // While r < divisor the borrow and the trial sign agree; either one rejects.
  assign take   = ~(borrow | trial[WIDTH]);
  assign accept = bus.start && (state == ST_IDLE || state == ST_DONE);

  always_comb begin
    r_next      = take ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    q_next      = q;
    q_next[cnt] = take;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_next = (bus.divisor == '0) ? ST_DONE : ST_RUN;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt == '0) begin
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      dvd_reg <= '0;
      dvs_reg <= '0;
      r       <= '0;
      q       <= '0;
      quo_reg <= '0;
      rem_reg <= '0;
      dbz_reg <= 1'b0;
    end else if (accept) begin
      dvd_reg <= bus.dividend;
      dvs_reg <= bus.divisor;
      cnt     <= CNT_W'(WIDTH - 1);
      r       <= '0;
      q       <= '0;
      if (bus.divisor == '0) begin
        quo_reg <= WIDTH'(DIV_ZERO_Q);
        rem_reg <= bus.dividend;
        dbz_reg <= 1'b1;
      end
    end else if (state == ST_RUN) begin
      r   <= r_next;
      q   <= q_next;
      cnt <= cnt - 1'b1;
      if (cnt == '0) begin
        quo_reg <= q_next;
        rem_reg <= r_next;
        dbz_reg <= 1'b0;
      end
    end
  end

  assign bus.busy        = (state == ST_RUN);
  assign bus.done        = (state == ST_DONE);
  assign bus.quotient    = quo_reg;
  assign bus.remainder   = rem_reg;
  assign bus.div_by_zero = dbz_reg;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider8.sv
// ==== tb_seq_divider8 : self-checking bench against an arithmetic reference ====
// ==== Rev 1.0                                                               ====
`default_nettype none

module tb_seq_divider8;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  seq_divider8_if #(.WIDTH(8)) dif ();

  seq_divider8 #(
    .WIDTH (8),
    .CNT_W (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] q, output logic [7:0] r,
                                output logic z);
    if (b == 8'd0) begin
      q = 8'hFF; r = a; z = 1'b1;
    end else begin
      q = a / b; r = a % b; z = 1'b0;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start sampled at the next edge; operand inputs are then scrambled to prove capture.
  task automatic launch(input logic [7:0] a, input logic [7:0] b);
    dif.start    = 1'b1;
    dif.dividend = a;
    dif.divisor  = b;
    step();
    dif.start    = 1'b0;
    dif.dividend = 8'($urandom);
    dif.divisor  = 8'($urandom);
  endtask

  task automatic wait_done(input int c0, output int lat, output int bc);
    int c;
    c   = c0;
    bc  = 0;
    lat = -1;
    while (c <= 30) begin
      if (dif.done) begin
        lat = c;
        break;
      end
      if (dif.busy) bc++;
      step();
      c++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dif.start = 1'b0; dif.dividend = 8'd0; dif.divisor = 8'd0;
    step(); step();
    checks++; if (dif.busy !== 1'b0 || dif.done !== 1'b0) begin
      errors++; $display("FAIL reset_handshake: busy=%b done=%b expected 0 0", dif.busy, dif.done);
    end
    checks++; if (dif.quotient !== 8'd0 || dif.remainder !== 8'd0 || dif.div_by_zero !== 1'b0) begin
      errors++; $display("FAIL reset_results: q=%0d r=%0d z=%b expected 0 0 0",
                         dif.quotient, dif.remainder, dif.div_by_zero);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int lat, bc;
    launch(8'd100, 8'd7);
    wait_done(1, lat, bc);
    checks++; if (lat !== 9 || bc !== 8) begin
      errors++; $display("FAIL basic_timing: done_cycle=%0d busy_cycles=%0d expected 9 8", lat, bc);
    end
    checks++; if (dif.quotient !== 8'd14 || dif.remainder !== 8'd2 || dif.div_by_zero !== 1'b0) begin
      errors++; $display("FAIL basic_result: q=%0d r=%0d z=%b expected 14 2 0",
                         dif.quotient, dif.remainder, dif.div_by_zero);
    end
    checks++; if (dif.busy !== 1'b0) begin
      errors++; $display("FAIL basic_busy_in_done: busy=%b expected 0", dif.busy);
    end
    step();
    checks++; if (dif.done !== 1'b0 || dif.quotient !== 8'd14 || dif.remainder !== 8'd2) begin
      errors++; $display("FAIL basic_hold: done=%b q=%0d r=%0d expected 0 14 2",
                         dif.done, dif.quotient, dif.remainder);
    end
  endtask

  task automatic test_edges();
    logic [7:0] av [3] = '{8'd255, 8'd5, 8'd255};
    logic [7:0] bv [3] = '{8'd1, 8'd9, 8'd255};
    logic [7:0] eq, er;
    logic       ez;
    int         lat, bc;
    for (int i = 0; i < 3; i++) begin
      model(av[i], bv[i], eq, er, ez);
      launch(av[i], bv[i]);
      wait_done(1, lat, bc);
      checks++; if (lat !== 9) begin
        errors++; $display("FAIL edge_latency[%0d]: done_cycle=%0d expected 9", i, lat);
      end
      checks++; if (dif.quotient !== eq || dif.remainder !== er || dif.div_by_zero !== ez) begin
        errors++; $display("FAIL edge_result[%0d] %0d/%0d: q=%0d r=%0d z=%b expected %0d %0d %b",
                           i, av[i], bv[i], dif.quotient, dif.remainder, dif.div_by_zero, eq, er, ez);
      end
      step();
    end
  endtask

  task automatic test_div_zero();
    int lat, bc;
    launch(8'd200, 8'd0);
    wait_done(1, lat, bc);
    checks++; if (lat !== 1 || bc !== 0) begin
      errors++; $display("FAIL divzero_timing: done_cycle=%0d busy_cycles=%0d expected 1 0", lat, bc);
    end
    checks++; if (dif.quotient !== 8'hFF || dif.remainder !== 8'd200 || dif.div_by_zero !== 1'b1) begin
      errors++; $display("FAIL divzero_result: q=%0h r=%0d z=%b expected ff 200 1",
                         dif.quotient, dif.remainder, dif.div_by_zero);
    end
    step();
  endtask

  task automatic test_ignore_start();
    int lat, bc;
    launch(8'd50, 8'd3);
    step(); step(); step();
    dif.start = 1'b1; dif.dividend = 8'd9; dif.divisor = 8'd2;
    step();
    dif.start = 1'b0;
    wait_done(5, lat, bc);
    checks++; if (lat !== 9) begin
      errors++; $display("FAIL ignore_latency: done_cycle=%0d expected 9", lat);
    end
    checks++; if (dif.quotient !== 8'd16 || dif.remainder !== 8'd2) begin
      errors++; $display("FAIL ignore_result: q=%0d r=%0d expected 16 2", dif.quotient, dif.remainder);
    end
    step();
    checks++; if (dif.busy !== 1'b0 || dif.done !== 1'b0) begin
      errors++; $display("FAIL ignore_no_restart: busy=%b done=%b expected 0 0", dif.busy, dif.done);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    launch(8'd20, 8'd6);
    wait_done(1, lat, bc);
    checks++; if (lat !== 9 || dif.quotient !== 8'd3 || dif.remainder !== 8'd2) begin
      errors++; $display("FAIL b2b_first: done_cycle=%0d q=%0d r=%0d expected 9 3 2",
                         lat, dif.quotient, dif.remainder);
    end
    dif.start = 1'b1; dif.dividend = 8'd9; dif.divisor = 8'd2;
    step();
    dif.start = 1'b0;
    wait_done(1, lat, bc);
    checks++; if (lat !== 9 || bc !== 8) begin
      errors++; $display("FAIL b2b_timing: done_cycle=%0d busy_cycles=%0d expected 9 8", lat, bc);
    end
    checks++; if (dif.quotient !== 8'd4 || dif.remainder !== 8'd1) begin
      errors++; $display("FAIL b2b_result: q=%0d r=%0d expected 4 1", dif.quotient, dif.remainder);
    end
    step();
  endtask

  task automatic test_reset_midop();
    int dones;
    launch(8'd77, 8'd5);
    step(); step(); step(); step();
    rst = 1'b1;
    step();
    checks++; if (dif.busy !== 1'b0 || dif.done !== 1'b0) begin
      errors++; $display("FAIL midreset_handshake: busy=%b done=%b expected 0 0", dif.busy, dif.done);
    end
    checks++; if (dif.quotient !== 8'd0 || dif.remainder !== 8'd0 || dif.div_by_zero !== 1'b0) begin
      errors++; $display("FAIL midreset_results: q=%0d r=%0d z=%b expected 0 0 0",
                         dif.quotient, dif.remainder, dif.div_by_zero);
    end
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (dif.done) dones++;
    end
    checks++; if (dones !== 0) begin
      errors++; $display("FAIL midreset_no_done: done_pulses=%0d expected 0", dones);
    end
  endtask

  task automatic test_random();
    logic [7:0] a, b, eq, er;
    logic       ez;
    int         lat, bc;
    for (int n = 0; n < 1000; n++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(1, 255));
      model(a, b, eq, er, ez);
      launch(a, b);
      wait_done(1, lat, bc);
      checks++; if (lat !== 9 || bc !== 8) begin
        errors++; $display("FAIL rand_timing %0d/%0d: done_cycle=%0d busy_cycles=%0d expected 9 8",
                           a, b, lat, bc);
      end
      checks++; if (dif.quotient !== eq || dif.remainder !== er || dif.div_by_zero !== 1'b0) begin
        errors++; $display("FAIL rand_result %0d/%0d: q=%0d r=%0d z=%b expected %0d %0d 0",
                           a, b, dif.quotient, dif.remainder, dif.div_by_zero, eq, er);
      end
      checks++;
      if ((int'(dif.quotient) * int'(b) + int'(dif.remainder)) != int'(a) || dif.remainder >= b) begin
        errors++; $display("FAIL rand_invariant %0d/%0d: q=%0d r=%0d", a, b, dif.quotient, dif.remainder);
      end
      step();
      checks++; if (dif.done !== 1'b0) begin
        errors++; $display("FAIL rand_single_done %0d/%0d: done=%b expected 0", a, b, dif.done);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    dif.start = 1'b0; dif.dividend = 8'd0; dif.divisor = 8'd0;
    test_reset();
    test_basic();
    test_edges();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
